// File: rtl/vrased_reset_seq_if.sv
// vrased_reset_seq_if: violation inputs and reset/debug outputs of the VRASED reset sequencer
interface vrased_reset_seq_if #(parameter int NSRC = 6, parameter int CNT_W = 8);
  logic [15:0] pc;
  logic [NSRC-1:0] viol;
  logic cause_clr;
  logic reset;
  logic busy;
  logic [NSRC:0] cause;
  logic [CNT_W-1:0] viol_cnt;
  modport master(output pc, viol, cause_clr, input reset, busy, cause, viol_cnt);
  modport slave(input pc, viol, cause_clr, output reset, busy, cause, viol_cnt);
endinterface

// File: rtl/vrased_reset_seq.sv
// vrased_reset_seq: holds CPU reset, confirms restart at RESET_HANDLER, re-fires on timeout, keeps sticky causes
module vrased_reset_seq #(
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int NSRC = 6,
  parameter int HOLD_CYCLES = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic puc_rst,
  vrased_reset_seq_if.slave bus
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ASSERT, WAIT_PC} state_t;
  state_t state, state_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [NSRC:0] cause_n;
  logic [CNT_W-1:0] cnt_n, cnt_inc;
  logic fire, pc_ok;
  assign fire = |bus.viol;
  assign pc_ok = bus.pc == RESET_HANDLER;
  assign cnt_inc = &bus.viol_cnt ? bus.viol_cnt : bus.viol_cnt + CNT_W'(1);
  always_comb begin
    state_n = state;
    hcnt_n = hcnt;
    tcnt_n = tcnt;
    cause_n = bus.cause;
    cnt_n = bus.viol_cnt;
    case (state)
      IDLE:
        if (fire) begin
          state_n = ASSERT;
          hcnt_n = '0;
          cause_n = (bus.cause_clr ? '0 : bus.cause) | {1'b0, bus.viol};
          cnt_n = bus.cause_clr ? CNT_W'(1) : cnt_inc;
        end else if (bus.cause_clr) begin
          cause_n = '0;
          cnt_n = '0;
        end
      ASSERT: begin
        cause_n = bus.cause | {1'b0, bus.viol};
        if (hcnt == HW'(HOLD_CYCLES - 1)) begin
          state_n = WAIT_PC;
          tcnt_n = '0;
        end else hcnt_n = hcnt + HW'(1);
      end
      WAIT_PC:
        // a violation beats the pc match; the pc match beats the timeout
        if (fire || (!pc_ok && tcnt == TW'(TIMEOUT - 1))) begin
          state_n = ASSERT;
          hcnt_n = '0;
          cause_n = bus.cause | {~fire, bus.viol};
          cnt_n = cnt_inc;
        end else if (pc_ok) state_n = IDLE;
        else tcnt_n = tcnt + TW'(1);
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (puc_rst) begin
      state <= IDLE;
      hcnt <= '0;
      tcnt <= '0;
      bus.reset <= 1'b0;
      bus.busy <= 1'b0;
      bus.cause <= '0;
      bus.viol_cnt <= '0;
    end else begin
      state <= state_n;
      hcnt <= hcnt_n;
      tcnt <= tcnt_n;
      bus.reset <= state_n == ASSERT;
      bus.busy <= state_n != IDLE;
      bus.cause <= cause_n;
      bus.viol_cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_vrased_reset_seq.sv
// tb_vrased_reset_seq: scoreboard bench; each cycle pushes the hand-derived expected outputs
module tb_vrased_reset_seq;
  typedef struct packed {
    logic rst;
    logic busy;
    logic [6:0] cause;
    logic [7:0] cnt;
  } out_t;
  logic clk = 1'b0;
  logic puc_rst = 1'b1;
  int checks = 0;
  int errors = 0;
  out_t exp_q[$];
  out_t obs_q[$];
  vrased_reset_seq_if #(.NSRC(6), .CNT_W(8)) bus ();
  vrased_reset_seq dut (.clk(clk), .puc_rst(puc_rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic out_t mk(input logic r, input logic b, input logic [6:0] c, input logic [7:0] n);
    return {r, b, c, n};
  endfunction
  task automatic cyc(input logic [5:0] v, input logic [15:0] p, input logic c, input out_t e);
    bus.viol = v;
    bus.pc = p;
    bus.cause_clr = c;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    obs_q.push_back({bus.reset, bus.busy, bus.cause, bus.viol_cnt});
  endtask
  task automatic test_reset;
    out_t e, o;
    cyc(6'h3F, 16'h0000, 1'b0, mk(0, 0, 7'h00, 8'h00));
    cyc(6'h3F, 16'hE000, 1'b1, mk(0, 0, 7'h00, 8'h00));
    puc_rst = 1'b0;
    cyc(6'h00, 16'hE000, 1'b0, mk(0, 0, 7'h00, 8'h00));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset[%0d] got rst=%b busy=%b cause=%h cnt=%h want rst=%b busy=%b cause=%h cnt=%h",
                 i, o.rst, o.busy, o.cause, o.cnt, e.rst, e.busy, e.cause, e.cnt);
      end
    end
  endtask
  task automatic test_trigger;
    out_t e, o;
    cyc(6'h04, 16'hE000, 1'b0, mk(1, 1, 7'h04, 8'h01));
    cyc(6'h00, 16'hE000, 1'b0, mk(1, 1, 7'h04, 8'h01));
    cyc(6'h20, 16'hE000, 1'b0, mk(1, 1, 7'h24, 8'h01));
    cyc(6'h00, 16'hE000, 1'b0, mk(1, 1, 7'h24, 8'h01));
    cyc(6'h00, 16'hE000, 1'b0, mk(0, 1, 7'h24, 8'h01));
    cyc(6'h00, 16'h0000, 1'b0, mk(0, 0, 7'h24, 8'h01));
    cyc(6'h00, 16'h0000, 1'b0, mk(0, 0, 7'h24, 8'h01));
    cyc(6'h00, 16'h0000, 1'b1, mk(0, 0, 7'h00, 8'h00));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL trigger[%0d] got rst=%b busy=%b cause=%h cnt=%h want rst=%b busy=%b cause=%h cnt=%h",
                 i, o.rst, o.busy, o.cause, o.cnt, e.rst, e.busy, e.cause, e.cnt);
      end
    end
  endtask
  task automatic test_timeout;
    out_t e, o;
    cyc(6'h02, 16'hE000, 1'b0, mk(1, 1, 7'h02, 8'h01));
    for (int k = 0; k < 3; k++) cyc(6'h00, 16'hE000, 1'b0, mk(1, 1, 7'h02, 8'h01));
    cyc(6'h00, 16'hE000, 1'b0, mk(0, 1, 7'h02, 8'h01));
    for (int k = 0; k < 15; k++) cyc(6'h00, 16'hE000, 1'b0, mk(0, 1, 7'h02, 8'h01));
    cyc(6'h00, 16'hE000, 1'b0, mk(1, 1, 7'h42, 8'h02));
    for (int k = 0; k < 3; k++) cyc(6'h00, 16'hE000, 1'b0, mk(1, 1, 7'h42, 8'h02));
    cyc(6'h00, 16'hE000, 1'b0, mk(0, 1, 7'h42, 8'h02));
    cyc(6'h00, 16'h0000, 1'b0, mk(0, 0, 7'h42, 8'h02));
    cyc(6'h00, 16'h0000, 1'b1, mk(0, 0, 7'h00, 8'h00));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL timeout[%0d] got rst=%b busy=%b cause=%h cnt=%h want rst=%b busy=%b cause=%h cnt=%h",
                 i, o.rst, o.busy, o.cause, o.cnt, e.rst, e.busy, e.cause, e.cnt);
      end
    end
  endtask
  task automatic test_precedence;
    out_t e, o;
    cyc(6'h08, 16'hE000, 1'b0, mk(1, 1, 7'h08, 8'h01));
    for (int k = 0; k < 3; k++) cyc(6'h00, 16'hE000, 1'b0, mk(1, 1, 7'h08, 8'h01));
    cyc(6'h00, 16'hE000, 1'b0, mk(0, 1, 7'h08, 8'h01));
    cyc(6'h01, 16'h0000, 1'b0, mk(1, 1, 7'h09, 8'h02));
    for (int k = 0; k < 3; k++) cyc(6'h00, 16'h0000, 1'b0, mk(1, 1, 7'h09, 8'h02));
    cyc(6'h00, 16'h0000, 1'b0, mk(0, 1, 7'h09, 8'h02));
    cyc(6'h00, 16'h0000, 1'b0, mk(0, 0, 7'h09, 8'h02));
    cyc(6'h00, 16'h0000, 1'b1, mk(0, 0, 7'h00, 8'h00));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL precedence[%0d] got rst=%b busy=%b cause=%h cnt=%h want rst=%b busy=%b cause=%h cnt=%h",
                 i, o.rst, o.busy, o.cause, o.cnt, e.rst, e.busy, e.cause, e.cnt);
      end
    end
  endtask
  task automatic test_saturate;
    out_t e, o;
    logic [7:0] n;
    // viol held high re-fires on the first WAIT_PC cycle: five cycles per firing
    for (int k = 1; k <= 256; k++) begin
      n = k > 255 ? 8'hFF : 8'(k);
      for (int j = 0; j < 4; j++) cyc(6'h01, 16'hE000, 1'b0, mk(1, 1, 7'h01, n));
      cyc(6'h01, 16'hE000, 1'b0, mk(0, 1, 7'h01, n));
    end
    cyc(6'h00, 16'h0000, 1'b0, mk(0, 0, 7'h01, 8'hFF));
    cyc(6'h02, 16'hE000, 1'b0, mk(1, 1, 7'h03, 8'hFF));
    for (int k = 0; k < 3; k++) cyc(6'h00, 16'hE000, 1'b1, mk(1, 1, 7'h03, 8'hFF));
    cyc(6'h00, 16'hE000, 1'b1, mk(0, 1, 7'h03, 8'hFF));
    cyc(6'h00, 16'hE000, 1'b1, mk(0, 1, 7'h03, 8'hFF));
    cyc(6'h00, 16'h0000, 1'b0, mk(0, 0, 7'h03, 8'hFF));
    cyc(6'h10, 16'hE000, 1'b1, mk(1, 1, 7'h10, 8'h01));
    for (int k = 0; k < 3; k++) cyc(6'h00, 16'hE000, 1'b0, mk(1, 1, 7'h10, 8'h01));
    cyc(6'h00, 16'hE000, 1'b0, mk(0, 1, 7'h10, 8'h01));
    cyc(6'h00, 16'h0000, 1'b0, mk(0, 0, 7'h10, 8'h01));
    cyc(6'h00, 16'h0000, 1'b1, mk(0, 0, 7'h00, 8'h00));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL saturate[%0d] got rst=%b busy=%b cause=%h cnt=%h want rst=%b busy=%b cause=%h cnt=%h",
                 i, o.rst, o.busy, o.cause, o.cnt, e.rst, e.busy, e.cause, e.cnt);
      end
    end
  endtask
  initial begin
    bus.viol = '0;
    bus.pc = '0;
    bus.cause_clr = 1'b0;
    test_reset();
    test_trigger();
    test_timeout();
    test_precedence();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
